// File: rtl/pixel_histogram.sv
// Greyscale pixel histogram builder.
// Clears a 256-bin external RAM, then accumulates one pixel per cycle through
// a 3-stage read-modify-write pipeline with write forwarding. When a full frame
// has been counted, it hands off to a downstream cumulative-histogram stage.
module pixel_histogram #(
  parameter int unsigned WORD_SIZE  = 20,
  parameter int unsigned NUM_PIXELS = 384000
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iFrameStart,
  input  logic                 iValid,
  input  logic [7:0]           iPixel,
  output logic                 oReady,
  output logic [7:0]           oAddrRd,
  input  logic [WORD_SIZE-1:0] iQ,
  output logic [7:0]           oAddrWr,
  output logic [WORD_SIZE-1:0] oDataWr,
  output logic                 oWE,
  output logic                 oStartCum,
  input  logic                 iCumDone,
  output logic                 oBusy,
  output logic                 oOverflow
);

  // The counter only has to hold 0..NUM_PIXELS-1 while accumulating.
  localparam int unsigned CntW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [CntW-1:0] LastPix = CntW'(NUM_PIXELS - 1);
  localparam logic [WORD_SIZE-1:0] BinMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StFlush,
    StHandoff,
    StWait
  } state_e;

  state_e state_q, state_d;

  // Frame control registers
  logic [7:0]      clr_addr_q, clr_addr_d;
  logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
  logic            flush_cnt_q, flush_cnt_d;
  logic            ovf_q, ovf_d;

  // Read-modify-write pipeline: S1 waits for RAM data, S2 writes the update
  logic [7:0] addr_rd_q, addr_rd_d;
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_pix_q, s1_pix_d;
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_pix_q, s2_pix_d;

  // History of the last two S2 writes, used to forward over stale RAM reads
  logic                 w1_valid_q, w1_valid_d;
  logic [7:0]           w1_addr_q, w1_addr_d;
  logic [WORD_SIZE-1:0] w1_data_q, w1_data_d;
  logic                 w2_valid_q, w2_valid_d;
  logic [7:0]           w2_addr_q, w2_addr_d;
  logic [WORD_SIZE-1:0] w2_data_q, w2_data_d;

  logic                 accept;
  logic                 s2_fire;
  logic [WORD_SIZE-1:0] base;
  logic [WORD_SIZE-1:0] inc_data;
  logic                 sat;

  // A restart in the same cycle wins over pixel acceptance and over S2 retirement.
  assign accept  = (state_q == StAccum) && iValid && !iFrameStart;
  assign s2_fire = s2_valid_q && !iFrameStart;

  // Pick the freshest copy of the bin and compute its saturating increment
  always_comb begin
    base = iQ;
    if (w2_valid_q && (w2_addr_q == s2_pix_q)) base = w2_data_q;
    // The newer write takes priority over the older one.
    if (w1_valid_q && (w1_addr_q == s2_pix_q)) base = w1_data_q;
    sat      = (base == BinMax);
    inc_data = sat ? BinMax : (base + WORD_SIZE'(1));
  end

  // Frame FSM next-state and control counters
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    pix_cnt_d   = pix_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ovf_d       = ovf_q;

    if (s2_fire && sat) ovf_d = 1'b1;

    case (state_q)
      StIdle: begin
      end
      StClear: begin
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) state_d = StAccum;
      end
      StAccum: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + CntW'(1);
          if (pix_cnt_q == LastPix) begin
            state_d     = StFlush;
            flush_cnt_d = 1'b0;
          end
        end
      end
      StFlush: begin
        // Two cycles let the last pixel pass through S1 and S2.
        flush_cnt_d = 1'b1;
        if (flush_cnt_q) state_d = StHandoff;
      end
      StHandoff: begin
        state_d = StWait;
      end
      StWait: begin
        if (iCumDone) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A frame start from any state restarts the clear sweep.
    if (iFrameStart) begin
      state_d     = StClear;
      clr_addr_d  = 8'd0;
      pix_cnt_d   = '0;
      flush_cnt_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  // Pipeline advance; a frame start drops every in-flight pixel
  always_comb begin
    s1_valid_d = accept;
    s1_pix_d   = accept ? iPixel : s1_pix_q;
    addr_rd_d  = accept ? iPixel : addr_rd_q;

    s2_valid_d = s1_valid_q && !iFrameStart;
    s2_pix_d   = s1_pix_q;

    w1_valid_d = s2_fire;
    w1_addr_d  = s2_pix_q;
    w1_data_d  = inc_data;

    w2_valid_d = w1_valid_q && !iFrameStart;
    w2_addr_d  = w1_addr_q;
    w2_data_d  = w1_data_q;
  end

  // Status and RAM write-port outputs
  always_comb begin
    oReady    = (state_q == StAccum);
    oBusy     = (state_q != StIdle);
    oStartCum = (state_q == StHandoff) && !iFrameStart;
    oAddrRd   = addr_rd_q;
    oOverflow = ovf_q;

    oWE     = 1'b0;
    oAddrWr = 8'd0;
    oDataWr = '0;
    if (state_q == StClear) begin
      oWE     = 1'b1;
      oAddrWr = clr_addr_q;
    end else if (s2_fire) begin
      oWE     = 1'b1;
      oAddrWr = s2_pix_q;
      oDataWr = inc_data;
    end
  end

  // FSM and frame counter state
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= StIdle;
      clr_addr_q  <= 8'd0;
      pix_cnt_q   <= '0;
      flush_cnt_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      pix_cnt_q   <= pix_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Pipeline and write-history state
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addr_rd_q  <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_pix_q   <= 8'd0;
      s2_valid_q <= 1'b0;
      s2_pix_q   <= 8'd0;
      w1_valid_q <= 1'b0;
      w1_addr_q  <= 8'd0;
      w1_data_q  <= '0;
      w2_valid_q <= 1'b0;
      w2_addr_q  <= 8'd0;
      w2_data_q  <= '0;
    end else begin
      addr_rd_q  <= addr_rd_d;
      s1_valid_q <= s1_valid_d;
      s1_pix_q   <= s1_pix_d;
      s2_valid_q <= s2_valid_d;
      s2_pix_q   <= s2_pix_d;
      w1_valid_q <= w1_valid_d;
      w1_addr_q  <= w1_addr_d;
      w1_data_q  <= w1_data_d;
      w2_valid_q <= w2_valid_d;
      w2_addr_q  <= w2_addr_d;
      w2_data_q  <= w2_data_d;
    end
  end

endmodule

// File: tb/tb_pixel_histogram.sv
// Directed testbench for pixel_histogram: two instances (16-pixel frames with
// 20-bit bins, and 20-pixel frames with 4-bit bins) each backed by a simple
// registered-read RAM model.
module tb_pixel_histogram;

  localparam int unsigned WsA = 20;
  localparam int unsigned NpA = 16;
  localparam int unsigned WsB = 4;
  localparam int unsigned NpB = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic fill;

  logic           fs_a, valid_a, done_a;
  logic [7:0]     pix_a;
  logic           ready_a, we_a, start_a, busy_a, ovf_a;
  logic [7:0]     ard_a, awr_a;
  logic [WsA-1:0] q_a, dwr_a;

  logic           fs_b, valid_b, done_b;
  logic [7:0]     pix_b;
  logic           ready_b, we_b, start_b, busy_b, ovf_b;
  logic [7:0]     ard_b, awr_b;
  logic [WsB-1:0] q_b, dwr_b;

  logic [WsA-1:0] mem_a [256];
  logic [WsB-1:0] mem_b [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cnt    = 0;
  int start_cyc    = 0;
  int last_we_cyc  = 0;
  int last_acc_cyc = 0;
  int to_flag;

  logic [7:0] stim [16];
  int         gap  [16];

  always #5 clk = ~clk;

  pixel_histogram #(.WORD_SIZE(WsA), .NUM_PIXELS(NpA)) u_dut_a (
    .iClk(clk), .iRst_n(rst_n), .iFrameStart(fs_a), .iValid(valid_a), .iPixel(pix_a),
    .oReady(ready_a), .oAddrRd(ard_a), .iQ(q_a), .oAddrWr(awr_a), .oDataWr(dwr_a),
    .oWE(we_a), .oStartCum(start_a), .iCumDone(done_a), .oBusy(busy_a), .oOverflow(ovf_a)
  );

  pixel_histogram #(.WORD_SIZE(WsB), .NUM_PIXELS(NpB)) u_dut_b (
    .iClk(clk), .iRst_n(rst_n), .iFrameStart(fs_b), .iValid(valid_b), .iPixel(pix_b),
    .oReady(ready_b), .oAddrRd(ard_b), .iQ(q_b), .oAddrWr(awr_b), .oDataWr(dwr_b),
    .oWE(we_b), .oStartCum(start_b), .iCumDone(done_b), .oBusy(busy_b), .oOverflow(ovf_b)
  );

  // RAM models: registered read returning pre-write data, garbage preload.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 20'hABCDE;
        mem_b[i] <= 4'hA;
      end
    end else begin
      if (we_a) mem_a[awr_a] <= dwr_a;
      if (we_b) mem_b[awr_b] <= dwr_b;
    end
    q_a <= mem_a[ard_a];
    q_b <= mem_b[ard_b];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event log for instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_a) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (we_a) last_we_cyc <= cyc;
    if (valid_a && ready_a && !fs_a) last_acc_cyc <= cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame_a();
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
  endtask

  task automatic end_frame_a();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
  endtask

  // Drives stim[0..n-1] with gap[i] idle cycles before each pixel; while the
  // DUT is not ready it offers a decoy pixel 0x33 that must never be counted.
  task automatic drive_frame_a(input int n);
    int guard;
    to_flag = 0;
    for (int idx = 0; idx < n; idx++) begin
      valid_a = 1'b0;
      repeat (gap[idx]) tick();
      guard = 0;
      while (!ready_a && guard < 1000) begin
        valid_a = 1'b1;
        pix_a   = 8'h33;
        tick();
        guard++;
      end
      if (guard >= 1000) to_flag = 1;
      valid_a = 1'b1;
      pix_a   = stim[idx];
      tick();
    end
    valid_a = 1'b0;
  endtask

  task automatic wait_start_a(input int prev);
    int guard;
    guard = 0;
    while (start_cnt == prev && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) to_flag = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({busy_a, ready_a, we_a, start_a, ovf_a} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy_a, ready_a, we_a, start_a, ovf_a});
    else n_pass++;
    n_checks++;
    if ({ard_a, awr_a, dwr_a} !== '0)
      $display("FAIL reset_addr_data: got %h want 0", {ard_a, awr_a, dwr_a});
    else n_pass++;
    n_checks++;
    if ({busy_b, we_b, ovf_b, ready_b} !== 4'b0)
      $display("FAIL reset_b: got %b want 0000", {busy_b, we_b, ovf_b, ready_b});
    else n_pass++;
    fill  = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy_a, we_a} !== 2'b0)
      $display("FAIL reset_release: got %b want 00", {busy_a, we_a});
    else n_pass++;
  endtask

  task automatic test_sequential();
    int prev, errs, bad;
    logic [WsA-1:0] want;
    prev = start_cnt;
    for (int i = 0; i < 16; i++) begin
      stim[i] = 8'(i);
      gap[i]  = 0;
    end
    start_frame_a();
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL seq_busy_clear: got %b want 1", busy_a);
    else n_pass++;
    drive_frame_a(16);
    wait_start_a(prev);
    n_checks++;
    if (to_flag != 0) $display("FAIL seq_timeout: got %0d want 0", to_flag);
    else n_pass++;
    n_checks++;
    if (start_cyc - last_acc_cyc != 3)
      $display("FAIL seq_start_delay: got %0d want 3", start_cyc - last_acc_cyc);
    else n_pass++;
    n_checks++;
    if (last_we_cyc - last_acc_cyc != 2)
      $display("FAIL seq_last_write: got %0d want 2", last_we_cyc - last_acc_cyc);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      want = (i < 16) ? WsA'(1) : WsA'(0);
      if (mem_a[i] !== want) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL seq_bins: got %0d bad bins want 0", errs);
    else n_pass++;
    n_checks++;
    if (ovf_a !== 1'b0) $display("FAIL seq_ovf: got %b want 0", ovf_a);
    else n_pass++;
    // Held in WAIT with no done: stays busy, silent RAM, no extra start.
    bad = 0;
    repeat (40) begin
      tick();
      if (busy_a !== 1'b1 || we_a !== 1'b0 || start_a !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || start_cnt != prev + 1)
      $display("FAIL seq_wait_hold: got bad=%0d starts=%0d want 0 and %0d", bad,
               start_cnt - prev, 1);
    else n_pass++;
    end_frame_a();
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL seq_idle: got %b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_same_bin();
    int prev, errs;
    prev = start_cnt;
    for (int i = 0; i < 16; i++) begin
      stim[i] = 8'h7F;
      gap[i]  = 0;
    end
    start_frame_a();
    drive_frame_a(16);
    wait_start_a(prev);
    n_checks++;
    if (mem_a[8'h7F] !== 20'd16) $display("FAIL same_bin7f: got %0d want 16", mem_a[8'h7F]);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256; i++) if (i != 8'h7F && mem_a[i] !== 20'd0) errs++;
    n_checks++;
    if (errs != 0 || to_flag != 0)
      $display("FAIL same_others: got %0d bad bins timeout=%0d want 0", errs, to_flag);
    else n_pass++;
    n_checks++;
    if (ovf_a !== 1'b0) $display("FAIL same_ovf: got %b want 0", ovf_a);
    else n_pass++;
    end_frame_a();
  endtask

  task automatic test_alternating();
    int prev;
    prev = start_cnt;
    for (int i = 0; i < 16; i++) begin
      stim[i] = (i % 2 == 0) ? 8'h10 : 8'h20;
      gap[i]  = 0;
    end
    start_frame_a();
    drive_frame_a(16);
    wait_start_a(prev);
    n_checks++;
    if (mem_a[8'h10] !== 20'd8) $display("FAIL alt_bin10: got %0d want 8", mem_a[8'h10]);
    else n_pass++;
    n_checks++;
    if (mem_a[8'h20] !== 20'd8) $display("FAIL alt_bin20: got %0d want 8", mem_a[8'h20]);
    else n_pass++;
    n_checks++;
    if (start_cnt != prev + 1 || to_flag != 0)
      $display("FAIL alt_start: got %0d pulses timeout=%0d want 1", start_cnt - prev, to_flag);
    else n_pass++;
    end_frame_a();
  endtask

  task automatic test_gaps();
    int prev;
    prev = start_cnt;
    stim = '{8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h0A, 8'h09, 8'h0A,
             8'h0A, 8'h09, 8'h0A, 8'h09, 8'h09, 8'h0A, 8'h0A, 8'h09};
    gap  = '{0, 0, 1, 2, 3, 0, 0, 0, 1, 0, 2, 0, 0, 0, 3, 0};
    start_frame_a();
    drive_frame_a(16);
    wait_start_a(prev);
    n_checks++;
    if (mem_a[8'h09] !== 20'd10) $display("FAIL gap_bin09: got %0d want 10", mem_a[8'h09]);
    else n_pass++;
    n_checks++;
    if (mem_a[8'h0A] !== 20'd6) $display("FAIL gap_bin0a: got %0d want 6", mem_a[8'h0A]);
    else n_pass++;
    n_checks++;
    if (mem_a[8'h33] !== 20'd0) $display("FAIL gap_decoy33: got %0d want 0", mem_a[8'h33]);
    else n_pass++;
    end_frame_a();
  endtask

  task automatic test_abort();
    int prev, we_cnt, addr_err, guard, errs;
    logic [WsA-1:0] want;
    prev = start_cnt;
    for (int i = 0; i < 16; i++) begin
      stim[i] = 8'h40 + 8'(i);
      gap[i]  = 0;
    end
    start_frame_a();
    drive_frame_a(7);
    // Restart with pixels 6 and 7 still in flight.
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    we_cnt   = 0;
    addr_err = 0;
    guard    = 0;
    while (!ready_a && guard < 400) begin
      if (we_a) begin
        if (awr_a !== 8'(we_cnt) || dwr_a !== 20'd0) addr_err++;
        we_cnt++;
      end
      tick();
      guard++;
    end
    n_checks++;
    if (we_cnt != 256) $display("FAIL abort_clear_writes: got %0d want 256", we_cnt);
    else n_pass++;
    n_checks++;
    if (addr_err != 0) $display("FAIL abort_clear_order: got %0d errors want 0", addr_err);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem_a[i] !== 20'd0) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL abort_cleared: got %0d nonzero bins want 0", errs);
    else n_pass++;
    stim = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41,
             8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    drive_frame_a(16);
    wait_start_a(prev);
    n_checks++;
    if (start_cnt != prev + 1 || to_flag != 0)
      $display("FAIL abort_start_pulses: got %0d timeout=%0d want 1", start_cnt - prev, to_flag);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      want = (i == 8'h40 || i == 8'h41 || i == 0 || i == 255) ? WsA'(4) : WsA'(0);
      if (mem_a[i] !== want) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL abort_next_frame: got %0d bad bins want 0", errs);
    else n_pass++;
    end_frame_a();
  endtask

  task automatic test_reset_midframe();
    int bad;
    for (int i = 0; i < 16; i++) begin
      stim[i] = 8'h50;
      gap[i]  = 0;
    end
    start_frame_a();
    drive_frame_a(5);
    valid_a = 1'b1;
    pix_a   = 8'h12;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, ready_a, we_a, start_a, ovf_a, ard_a, awr_a, dwr_a} !== '0)
      $display("FAIL rstmid_async: got %h want 0",
               {busy_a, ready_a, we_a, start_a, ovf_a, ard_a, awr_a, dwr_a});
    else n_pass++;
    bad = 0;
    repeat (3) begin
      tick();
      if (we_a !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      if (we_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b0) bad++;
      tick();
    end
    valid_a = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int guard, not_ready, errs;
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    guard = 0;
    while (!ready_b && guard < 400) begin
      tick();
      guard++;
    end
    n_checks++;
    if (ovf_b !== 1'b0 || guard >= 400)
      $display("FAIL ovf_start: got ovf=%b guard=%0d want 0 and <400", ovf_b, guard);
    else n_pass++;
    not_ready = 0;
    for (int i = 0; i < 20; i++) begin
      valid_b = 1'b1;
      pix_b   = 8'h05;
      if (!ready_b) not_ready++;
      tick();
    end
    valid_b = 1'b0;
    n_checks++;
    if (not_ready != 0) $display("FAIL ovf_backpressure: got %0d stalls want 0", not_ready);
    else n_pass++;
    guard = 0;
    while (!start_b && guard < 100) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 100) $display("FAIL ovf_handoff: got timeout want start pulse");
    else n_pass++;
    tick();
    n_checks++;
    if (mem_b[5] !== 4'hF) $display("FAIL ovf_bin5: got %0d want 15", mem_b[5]);
    else n_pass++;
    n_checks++;
    if (ovf_b !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf_b);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256; i++) if (i != 5 && mem_b[i] !== 4'h0) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL ovf_others: got %0d bad bins want 0", errs);
    else n_pass++;
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    n_checks++;
    if (busy_b !== 1'b0 || ovf_b !== 1'b1)
      $display("FAIL ovf_idle: got busy=%b ovf=%b want 0 1", busy_b, ovf_b);
    else n_pass++;
    // A new frame clears the sticky flag.
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    n_checks++;
    if (ovf_b !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", ovf_b);
    else n_pass++;
  endtask

  initial begin
    rst_n   = 1'b0;
    fill    = 1'b1;
    fs_a    = 1'b0;
    valid_a = 1'b0;
    done_a  = 1'b0;
    pix_a   = 8'h00;
    fs_b    = 1'b0;
    valid_b = 1'b0;
    done_b  = 1'b0;
    pix_b   = 8'h00;
    to_flag = 0;
    test_reset();
    test_sequential();
    test_same_bin();
    test_alternating();
    test_gaps();
    test_abort();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

endmodule
